// File: rtl/nv_nvdla_pdp_mcif_rd_rsp_model.sv
// Memory-side responder for the PDP read DMA port. Requests are queued in a
// small FIFO and served one at a time. Each request waits LATENCY cycles and
// then returns size+1 beats of address-derived data. Beats are gated by the
// PDP latency-FIFO credit count.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready.
// Once valid is raised it holds, with a stable payload, until that edge.
module nv_nvdla_pdp_mcif_rd_rsp_model #(
    parameter int REQ_DEPTH = 4,
    parameter int CDT_DEPTH = 64,
    parameter int LATENCY   = 8
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,
    input  logic         pdp2mcif_rd_req_valid,
    output logic         pdp2mcif_rd_req_ready,
    input  logic [78:0]  pdp2mcif_rd_req_pd,
    output logic         mcif2pdp_rd_rsp_valid,
    input  logic         mcif2pdp_rd_rsp_ready,
    output logic [256:0] mcif2pdp_rd_rsp_pd,
    input  logic         pdp2mcif_rd_cdt_lat_fifo_pop,
    output logic [7:0]   rsp_credit_cnt,
    output logic         cdt_overflow_err,
    output logic         req_pending
);

    localparam int AW = $clog2(REQ_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] FULL_OCC = OW'(REQ_DEPTH);
    localparam logic [7:0]    CDT_MAX  = 8'(CDT_DEPTH);
    localparam logic [7:0]    LAT_INIT = 8'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LAT   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // Request FIFO storage and bookkeeping
    logic [78:0]   fifo_mem [REQ_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OW-1:0] occ_q, occ_d;
    logic          req_ready_q;
    logic          push, pop_req;
    logic [78:0]   head;

    // Burst engine state
    state_t        state_q, state_d;
    logic [63:0]   cur_addr_q, cur_addr_d;
    logic [14:0]   beats_left_q, beats_left_d;
    logic [7:0]    lat_cnt_q, lat_cnt_d;

    // Credits
    logic [7:0]    cdt_cnt_q, cdt_cnt_d;
    logic          cdt_err_q, cdt_err_d;

    logic          rsp_valid_w;
    logic          rsp_hs;
    logic [255:0]  beat_data;

    assign push    = pdp2mcif_rd_req_valid && req_ready_q;
    assign pop_req = (state_q == ST_IDLE) && (occ_q != '0);
    assign head    = fifo_mem[rd_ptr_q];

    // A beat is only offered while credits remain; since credits only drop on
    // a handshake, an offered beat can never lose its credit while waiting.
    assign rsp_valid_w = (state_q == ST_BURST) && (cdt_cnt_q != 8'd0);
    assign rsp_hs      = rsp_valid_w && mcif2pdp_rd_rsp_ready;

    // FIFO occupancy next-state; ready is registered from the next occupancy
    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop_req})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // FIFO payload storage; reset only needs to clear the pointers
    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= pdp2mcif_rd_req_pd;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            req_ready_q <= 1'b1;
        end else begin
            if (push)    wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_req) rd_ptr_q <= rd_ptr_q + AW'(1);
            occ_q       <= occ_d;
            req_ready_q <= (occ_d != FULL_OCC);
        end
    end

    // Burst engine next-state: pop in IDLE, count latency, stream beats
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        lat_cnt_d    = lat_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (occ_q != '0) begin
                    cur_addr_d   = head[63:0];
                    beats_left_d = head[78:64];
                    lat_cnt_d    = LAT_INIT;
                    state_d      = (LATENCY == 0) ? ST_BURST : ST_LAT;
                end
            end
            ST_LAT: begin
                // The count reaches zero on the edge that enters BURST, so
                // exactly LATENCY cycles are spent here.
                lat_cnt_d = lat_cnt_q - 8'd1;
                if (lat_cnt_q == 8'd1) state_d = ST_BURST;
            end
            ST_BURST: begin
                if (rsp_hs) begin
                    cur_addr_d = cur_addr_q + 64'd32;
                    if (beats_left_q == 15'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        beats_left_d = beats_left_q - 15'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst engine state registers
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            lat_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            lat_cnt_q    <= lat_cnt_d;
        end
    end

    // Credit counter next-state: handshake consumes, pop returns
    always_comb begin
        cdt_cnt_d = cdt_cnt_q;
        cdt_err_d = cdt_err_q;
        if (rsp_hs && !pdp2mcif_rd_cdt_lat_fifo_pop) begin
            cdt_cnt_d = cdt_cnt_q - 8'd1;
        end else if (pdp2mcif_rd_cdt_lat_fifo_pop && !rsp_hs) begin
            if (cdt_cnt_q == CDT_MAX) begin
                cdt_err_d = 1'b1;
            end else begin
                cdt_cnt_d = cdt_cnt_q + 8'd1;
            end
        end
    end

    // Credit counter and sticky overflow flag
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cdt_cnt_q <= CDT_MAX;
            cdt_err_q <= 1'b0;
        end else begin
            cdt_cnt_q <= cdt_cnt_d;
            cdt_err_q <= cdt_err_d;
        end
    end

    // Beat payload: address word replicated, top word tagged with beats left
    always_comb begin
        beat_data = '0;
        for (int w = 0; w < 8; w++) begin
            beat_data[w*32 +: 32] = cur_addr_q[31:0];
        end
        beat_data[255:224] = beat_data[255:224] ^ {17'b0, beats_left_q};
    end

    assign pdp2mcif_rd_req_ready = req_ready_q;
    assign mcif2pdp_rd_rsp_valid = rsp_valid_w;
    assign mcif2pdp_rd_rsp_pd    = rsp_valid_w ? {1'b1, beat_data} : '0;
    assign rsp_credit_cnt        = cdt_cnt_q;
    assign cdt_overflow_err      = cdt_err_q;
    assign req_pending           = (occ_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_nv_nvdla_pdp_mcif_rd_rsp_model.sv
// Bench for the PDP read-response model: scoreboard of expected beats built
// from each accepted request, a credit model, and per-feature scenario tasks.
module tb_nv_nvdla_pdp_mcif_rd_rsp_model;

    localparam int TB_REQ = 4;
    localparam int TB_CDT = 4;
    localparam int TB_LAT = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [78:0]  req_pd = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [256:0] rsp_pd;
    logic         cdt_pop = 1'b0;
    logic [7:0]   credit_cnt;
    logic         ovf_err;
    logic         pending;

    nv_nvdla_pdp_mcif_rd_rsp_model #(
        .REQ_DEPTH(TB_REQ), .CDT_DEPTH(TB_CDT), .LATENCY(TB_LAT)
    ) dut (
        .nvdla_core_clk              (clk),
        .nvdla_core_rstn             (rst_n),
        .pdp2mcif_rd_req_valid       (req_valid),
        .pdp2mcif_rd_req_ready       (req_ready),
        .pdp2mcif_rd_req_pd          (req_pd),
        .mcif2pdp_rd_rsp_valid       (rsp_valid),
        .mcif2pdp_rd_rsp_ready       (rsp_ready),
        .mcif2pdp_rd_rsp_pd          (rsp_pd),
        .pdp2mcif_rd_cdt_lat_fifo_pop(cdt_pop),
        .rsp_credit_cnt              (credit_cnt),
        .cdt_overflow_err            (ovf_err),
        .req_pending                 (pending)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model / scoreboard ----------------
    logic [256:0] exp_q[$];
    logic [7:0]   mdl_cnt = 8'(TB_CDT);
    logic         mdl_err = 1'b0;
    int           beats_seen = 0;
    logic         hold_prev = 1'b0;
    logic [256:0] hold_pd = '0;

    function automatic logic [256:0] beat_of(input logic [63:0] a, input logic [14:0] bl);
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = a[31:0];
        d[255:224] = d[255:224] ^ {17'b0, bl};
        return {1'b1, d};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mdl_cnt   = 8'(TB_CDT);
            mdl_err   = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                for (int i = 0; i <= int'(req_pd[78:64]); i++)
                    exp_q.push_back(beat_of(req_pd[63:0] + 64'(i) * 64'd32,
                                            15'(int'(req_pd[78:64]) - i)));
            end
            n_cmp++;
            if (credit_cnt !== mdl_cnt) begin
                n_bad++;
                $display("FAIL credit_cnt: got %0d expected %0d at %0t", credit_cnt, mdl_cnt, $time);
            end
            n_cmp++;
            if (ovf_err !== mdl_err) begin
                n_bad++;
                $display("FAIL overflow_err: got %0b expected %0b at %0t", ovf_err, mdl_err, $time);
            end
            if (hold_prev) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_pd !== hold_pd) begin
                    n_bad++;
                    $display("FAIL rsp_stable: valid=%0b pd=%h expected valid=1 pd=%h", rsp_valid, rsp_pd, hold_pd);
                end
            end
            if (rsp_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_beat: pd=%h expected no beat at %0t", rsp_pd, $time);
                    if (rsp_ready) beats_seen++;
                end else begin
                    if (rsp_pd !== exp_q[0]) begin
                        n_bad++;
                        $display("FAIL beat_data: got %h expected %h", rsp_pd, exp_q[0]);
                    end
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        beats_seen++;
                    end
                end
            end
            hold_prev = rsp_valid && !rsp_ready;
            hold_pd   = rsp_pd;
            if (rsp_valid && rsp_ready && !cdt_pop) mdl_cnt = mdl_cnt - 8'd1;
            else if (cdt_pop && !(rsp_valid && rsp_ready)) begin
                if (mdl_cnt == 8'(TB_CDT)) mdl_err = 1'b1;
                else mdl_cnt = mdl_cnt + 8'd1;
            end
        end
    end

    // ---------------- background drivers ----------------
    logic auto_pop = 1'b1;
    logic rand_ready = 1'b0;
    int   pop_pct = 100;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_pop) cdt_pop = (mdl_cnt < 8'(TB_CDT)) && ($urandom_range(1, 100) <= pop_pct);
            if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end one time unit after a rising edge.
    task automatic send_req(input logic [63:0] addr, input logic [14:0] size);
        req_pd    = {size, addr};
        req_valid = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_req: not accepted, ready=%0b expected 1", req_ready);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (!pending && !rsp_valid) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_idle: pending=%0b after %0d cycles expected 0", pending, budget);
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: rsp_valid=0 expected 1 within 60 cycles", tag);
    endtask

    task automatic restore_credits();
        auto_pop = 1'b1;
        for (int k = 0; k < 100 && mdl_cnt != 8'(TB_CDT); k++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        auto_pop = 1'b0;
        cdt_pop  = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b expected 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b expected 0", rsp_valid); end
        n_cmp++; if (rsp_pd !== '0) begin n_bad++; $display("FAIL reset_pd: got %h expected 0", rsp_pd); end
        n_cmp++; if (credit_cnt !== 8'(TB_CDT)) begin n_bad++; $display("FAIL reset_cnt: got %0d expected %0d", credit_cnt, TB_CDT); end
        n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b expected 0", ovf_err); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %0b expected 0", pending); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset: ready=%0b valid=%0b expected 1/0", req_ready, rsp_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int k;
        rsp_ready = 1'b1;
        auto_pop  = 1'b1;
        send_req(64'h1000, 15'd0);
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 3) begin
                n_cmp++;
                if (pending !== 1'b1) begin n_bad++; $display("FAIL single_pending: got %0b expected 1", pending); end
            end
            if (rsp_valid) break;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (k != TB_LAT + 2) begin n_bad++; $display("FAIL single_latency: got %0d cycles expected %0d", k, TB_LAT + 2); end
        n_cmp++;
        if (rsp_pd[31:0] !== 32'h1000 || rsp_pd[255:224] !== 32'h1000 || rsp_pd[256] !== 1'b1)
            begin n_bad++; $display("FAIL single_data: w0=%h w7=%h mask=%0b expected 1000/1000/1", rsp_pd[31:0], rsp_pd[255:224], rsp_pd[256]); end
        @(posedge clk);
        #1;
        wait_idle(50);
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL single_drain: %0d beats left expected 0", exp_q.size()); end
    endtask

    task automatic test_burst_backpressure();
        int n = 0;
        rsp_ready = 1'b1;
        send_req(64'h2000, 15'd3);
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                n_cmp++;
                if (rsp_pd[31:0] !== 32'h2000 + 32'(n) * 32'h20) begin
                    n_bad++;
                    $display("FAIL burst_word0: got %h expected %h", rsp_pd[31:0], 32'h2000 + 32'(n) * 32'h20);
                end
                n++;
            end
            @(posedge clk);
            #1;
            rsp_ready = !rsp_ready;
        end
        rsp_ready = 1'b1;
        n_cmp++;
        if (n != 4) begin n_bad++; $display("FAIL burst_count: got %0d beats expected 4", n); end
        wait_idle(20);
        n_cmp++;
        if (pending !== 1'b0 || exp_q.size() != 0) begin n_bad++; $display("FAIL burst_idle: pending=%0b left=%0d expected 0/0", pending, exp_q.size()); end
    endtask

    task automatic pop_twice();
        @(posedge clk); #1; cdt_pop = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; cdt_pop = 1'b0;
    endtask

    task automatic test_credit_starvation();
        int base;
        restore_credits();
        rsp_ready = 1'b1;
        base = beats_seen;
        send_req(64'h3000, 15'd7);
        repeat (30) @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        n_cmp++; if (beats_seen - base != 4) begin n_bad++; $display("FAIL starve_beats: got %0d expected 4", beats_seen - base); end
        n_cmp++; if (rsp_valid !== 1'b0 || credit_cnt !== 8'd0) begin n_bad++; $display("FAIL starve_block: valid=%0b cnt=%0d expected 0/0", rsp_valid, credit_cnt); end
        pop_twice();
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        n_cmp++; if (beats_seen - base != 6) begin n_bad++; $display("FAIL starve_resume: got %0d expected 6", beats_seen - base); end
        pop_twice();
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        n_cmp++; if (beats_seen - base != 8) begin n_bad++; $display("FAIL starve_done: got %0d expected 8", beats_seen - base); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL starve_pending: got %0b expected 0", pending); end
        @(posedge clk);
        #1;
        auto_pop = 1'b1;
    endtask

    task automatic test_fifo_full();
        int base, total;
        logic [14:0] sz;
        auto_pop  = 1'b1;
        rsp_ready = 1'b0;
        base  = beats_seen;
        total = 2;
        send_req({$urandom, $urandom} & ~64'h1f, 15'd1);
        wait_valid("fifo_first_valid");
        for (int i = 0; i < TB_REQ; i++) begin
            sz = 15'($urandom_range(0, 2));
            total += int'(sz) + 1;
            send_req({$urandom, $urandom} & ~64'h1f, sz);
        end
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL fifo_full_ready: got %0b expected 0", req_ready); end
        @(posedge clk);
        #1;
        req_pd    = {15'd2, 64'h0000_0000_0000_9000};
        req_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL fifo_hold_ready: got %0b expected 0", req_ready); end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        total += 3;
        send_req(64'h9000, 15'd2);
        wait_idle(500);
        n_cmp++; if (beats_seen - base != total) begin n_bad++; $display("FAIL fifo_beats: got %0d expected %0d", beats_seen - base, total); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL fifo_order: %0d beats left expected 0", exp_q.size()); end
    endtask

    task automatic test_credit_simul();
        restore_credits();
        rsp_ready = 1'b0;
        send_req(64'h4000, 15'd3);
        wait_valid("simul_valid");
        rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (credit_cnt !== 8'd3) begin n_bad++; $display("FAIL simul_pre: cnt=%0d expected 3", credit_cnt); end
        @(posedge clk); #1; rsp_ready = 1'b1; cdt_pop = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0; cdt_pop = 1'b0;
        @(negedge clk);
        n_cmp++; if (credit_cnt !== 8'd3) begin n_bad++; $display("FAIL simul_hs_pop: cnt=%0d expected 3", credit_cnt); end
        @(posedge clk); #1; rsp_ready = 1'b1; cdt_pop = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; cdt_pop = 1'b0;
        @(negedge clk);
        n_cmp++; if (credit_cnt !== 8'd3 || rsp_valid !== 1'b0 || pending !== 1'b0)
            begin n_bad++; $display("FAIL simul_end: cnt=%0d valid=%0b pend=%0b expected 3/0/0", credit_cnt, rsp_valid, pending); end
        @(posedge clk); #1; cdt_pop = 1'b1;
        @(posedge clk); #1; cdt_pop = 1'b0;
        @(negedge clk);
        n_cmp++; if (credit_cnt !== 8'(TB_CDT) || ovf_err !== 1'b0) begin n_bad++; $display("FAIL simul_full: cnt=%0d err=%0b expected %0d/0", credit_cnt, ovf_err, TB_CDT); end
        @(posedge clk); #1; cdt_pop = 1'b1;
        @(posedge clk); #1; cdt_pop = 1'b0;
        @(negedge clk);
        n_cmp++; if (credit_cnt !== 8'(TB_CDT) || ovf_err !== 1'b1) begin n_bad++; $display("FAIL simul_overflow: cnt=%0d err=%0b expected %0d/1", credit_cnt, ovf_err, TB_CDT); end
        @(posedge clk);
        #1;
        auto_pop = 1'b1;
    endtask

    task automatic test_random();
        int base, total;
        logic [63:0] a;
        logic [14:0] sz;
        base  = beats_seen;
        total = 0;
        pop_pct    = 50;
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a  = {$urandom, $urandom} & ~64'h1f;
            sz = 15'($urandom_range(0, 5));
            if (i == 5) begin
                a  = 64'hFFFF_FFFF_FFFF_FFC0;
                sz = 15'd3;
            end
            total += int'(sz) + 1;
            send_req(a, sz);
        end
        wait_idle(3000);
        rand_ready = 1'b0;
        rsp_ready  = 1'b1;
        pop_pct    = 100;
        n_cmp++; if (beats_seen - base != total) begin n_bad++; $display("FAIL random_beats: got %0d expected %0d", beats_seen - base, total); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL random_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_max_size();
        int base;
        base      = beats_seen;
        rsp_ready = 1'b1;
        auto_pop  = 1'b1;
        send_req({$urandom, $urandom} & ~64'h1f, 15'h7FFF);
        wait_idle(40000);
        n_cmp++; if (beats_seen - base != 32768) begin n_bad++; $display("FAIL max_beats: got %0d expected 32768", beats_seen - base); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL max_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_burst();
        int base;
        base      = beats_seen;
        rsp_ready = 1'b1;
        auto_pop  = 1'b1;
        send_req(64'h5000, 15'd15);
        for (int k = 0; k < 200 && beats_seen - base < 5; k++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #2;
        auto_pop = 1'b0;
        cdt_pop  = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_pd !== '0)
            begin n_bad++; $display("FAIL midrst_rsp: ready=%0b valid=%0b pd=%h expected 1/0/0", req_ready, rsp_valid, rsp_pd); end
        n_cmp++; if (credit_cnt !== 8'(TB_CDT) || ovf_err !== 1'b0 || pending !== 1'b0)
            begin n_bad++; $display("FAIL midrst_state: cnt=%0d err=%0b pend=%0b expected %0d/0/0", credit_cnt, ovf_err, pending, TB_CDT); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base  = beats_seen;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++; if (beats_seen != base || pending !== 1'b0 || rsp_valid !== 1'b0)
            begin n_bad++; $display("FAIL midrst_quiet: beats=%0d pend=%0b valid=%0b expected 0/0/0", beats_seen - base, pending, rsp_valid); end
        auto_pop = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_burst_backpressure();
        test_credit_starvation();
        test_fifo_full();
        test_credit_simul();
        test_random();
        test_max_size();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_pdp_mcif_rd_rsp_model.md
Name: nv_nvdla_pdp_mcif_rd_rsp_model

Overview:
- Memory-side responder for the PDP read DMA interface (pdp2mcif_rd_req_* / mcif2pdp_rd_rsp_*). It is the other end of the PDP read port.
- It accepts read requests, waits a programmable latency, and returns `size+1` 256-bit beats of address-derived data.
- It honours the PDP latency-FIFO credit protocol.
- It replaces MCIF in PDP subsystem benches and in FPGA bring-up builds.

Parameters:
- REQ_DEPTH, 4, request FIFO entries (power of 2, ≥2).
- CDT_DEPTH, 64, response credits, matching the PDP latency FIFO depth (≤255).
- LATENCY, 8, idle cycles between request pop and first beat (0..255).

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  async active-low reset
- pdp2mcif_rd_req_valid  in  1  request valid
- pdp2mcif_rd_req_ready  out  1  request ready
- pdp2mcif_rd_req_pd  in  79  [63:0] byte addr (32B aligned), [78:64] size = atoms−1
- mcif2pdp_rd_rsp_valid  out  1  response beat valid
- mcif2pdp_rd_rsp_ready  in  1  response beat ready
- mcif2pdp_rd_rsp_pd  out  257  [255:0] data, [256] mask
- pdp2mcif_rd_cdt_lat_fifo_pop  in  1  one credit returned per cycle high
- rsp_credit_cnt  out  8  credits currently available
- cdt_overflow_err  out  1  sticky: credit returned while counter full
- req_pending  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset is asynchronous, active-low.
  - Reset values: req_ready=1, rsp_valid=0, rsp_pd=0, rsp_credit_cnt=CDT_DEPTH, cdt_overflow_err=0, req_pending=0.
  - FIFO empty, FSM=IDLE.
  - Reset mid-burst discards all queued and in-flight requests. No beat appears after reset deassertion until a new request arrives.
- Request FIFO:
  - req_ready = !full, registered from occupancy.
  - Push on valid&&ready.
  - A push and a pop in the same cycle while full is not allowed, because ready is already 0.
  - A push into an empty FIFO is visible to the FSM the next cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head. Latch addr into cur_addr and size into beats_left (15b). Load lat_cnt=LATENCY. Go to LAT, or go to BURST if LATENCY==0.
  - LAT: decrement lat_cnt each cycle. When it reaches 0, go to BURST next cycle.
  - BURST: raise rsp_valid only when rsp_credit_cnt>0.
    - Once raised, rsp_valid and rsp_pd stay stable until ready.
    - On each handshake: cur_addr += 32 (mod 2^64).
    - If beats_left==0, go to IDLE; otherwise decrement beats_left and stay.
    - The next beat may be valid the cycle after a handshake, so full throughput is 1 beat/cycle.
- Every request costs exactly one IDLE cycle between its last beat and the next request's LAT/BURST.
- Latency: request accepted in cycle t into an empty, idle block gives first rsp_valid in cycle t+2+LATENCY, provided credits >0.
- Data encoding:
  - data = 8 copies of cur_addr[31:0], word 0 in bits [31:0].
  - Then data[255:224] is XORed with {17'b0, beats_left[14:0]}.
  - mask=1.
- Credits:
  - Decrement by 1 on each beat handshake. Increment by 1 on pop.
  - Handshake and pop in the same cycle leave the count unchanged.
  - A pop while the count is CDT_DEPTH with no handshake that cycle holds the count and sets cdt_overflow_err. The error is cleared only by reset.
  - A count of 0 blocks a new rsp_valid. A beat already valid is never withdrawn.
- size=0x7FFF gives 32768 beats. The beat counter must not wrap early.
- An address wrap past 2^64−32 wraps to 0 silently.

Test Plan:
- Single request: LATENCY=8, addr=0x1000, size=0, accepted at cycle 10 → one beat valid at cycle 20; data word0=0x00001000, word7=0x00001000; mask=1.
- Burst with backpressure: size=3, addr=0x2000, ready toggling 1/0 → 4 beats; word0 = 0x2000, 0x2020, 0x2040, 0x2060; pd stable on every ready=0 cycle; then IDLE.
- Credit starvation: CDT_DEPTH=4, size=7, no pops → exactly 4 beats, then valid stays 0 and rsp_credit_cnt=0. Two pops → 2 more beats. Two more pops → the burst completes.
- FIFO full: hold rsp_ready=0 and push 5 requests with REQ_DEPTH=4 → req_ready low after FIFO fill; 5th accepted only after first pop; responses in order.
- Simultaneous handshake and pop at count 3 → count stays 3. Pop at count CDT_DEPTH → cdt_overflow_err=1, count stays CDT_DEPTH.
- Reset mid-burst: size=15, reset asserted after beat 5 → outputs reach reset values immediately; no further beats; req_pending=0.
